key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range >= 2.
REQ-003 Parameter REPEAT_DELAY_CYCLES, default 25000000: cycles from the accepted press to the first auto-repeat pulse; legal range >= 2.
REQ-004 Parameter REPEAT_PERIOD_CYCLES, default 5000000: cycles between subsequent auto-repeat pulses; legal range >= 2.
REQ-005 i_clock  input  1  system clock (50 MHz board clock).
REQ-006 i_reset_n  input  1  reset; synchronous, active-low; single clock domain i_clock.
REQ-007 i_key  input  NUM_KEYS  raw board push buttons; asynchronous; active-low (0 = pressed).
REQ-008 i_repeat_en  input  1  1 = auto-repeat pulses enabled on all keys.
REQ-009 o_key_state  output  NUM_KEYS  debounced level; active-high (1 = pressed).
REQ-010 o_key_press  output  NUM_KEYS  one-cycle pulse per accepted press.
REQ-011 o_key_release  output  NUM_KEYS  one-cycle pulse per accepted release.
REQ-012 o_key_repeat  output  NUM_KEYS  one-cycle auto-repeat pulse while held.
REQ-013 o_any_press  output  1  OR of all o_key_press bits, same cycle.

Function
REQ-014 Each i_key bit SHALL pass through a 2-flop synchronizer, then be inverted to form an active-high sampled level p.
REQ-015 Each key SHALL have an independent FSM: RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK, plus a debounce counter and a repeat counter; counter widths SHALL be $clog2 of the largest parameter, with no overflow.
REQ-016 RELEASED: p=1 -> PRESS_CHECK with the debounce counter cleared; otherwise hold.
REQ-017 PRESS_CHECK: p=0 -> RELEASED with the counter cleared (bounce rejected, no pulse); p=1 -> increment; on the cycle p=1 has been seen for DEBOUNCE_CYCLES consecutive cycles -> PRESSED.
REQ-018 RELEASE_CHECK SHALL mirror PRESS_CHECK with the roles of p swapped: p=1 -> back to PRESSED; DEBOUNCE_CYCLES consecutive p=0 -> RELEASED.
REQ-019 o_key_state SHALL be 1 in PRESSED and RELEASE_CHECK, and 0 otherwise.
REQ-020 o_key_press SHALL pulse high for exactly one cycle, registered, in the first cycle o_key_state=1.
REQ-021 o_key_release SHALL pulse for one cycle in the first cycle o_key_state=0.
REQ-022 Latency: pin stable low from the sampling edge k -> o_key_state rises and o_key_press pulses at edge k+2+DEBOUNCE_CYCLES; release SHALL have identical latency.
REQ-023 Repeat counter: cleared on entry to PRESSED from PRESS_CHECK; increments in PRESSED; frozen in RELEASE_CHECK; cleared in RELEASED/PRESS_CHECK.
REQ-024 With i_repeat_en=1, o_key_repeat SHALL pulse REPEAT_DELAY_CYCLES cycles after the o_key_press pulse, then every REPEAT_PERIOD_CYCLES while in PRESSED.
REQ-025 o_key_repeat SHALL never pulse in RELEASE_CHECK or RELEASED; a bounce that returns RELEASE_CHECK to PRESSED SHALL resume the schedule without a new o_key_press pulse.
REQ-026 With i_repeat_en=0, o_key_repeat SHALL be 0 while the repeat counter keeps running; enabling mid-hold SHALL follow the running schedule.
REQ-027 Keys SHALL be fully independent; simultaneous accepted presses SHALL pulse their o_key_press bits in the same cycle, and o_any_press SHALL assert once.

Reset
REQ-028 With i_reset_n=0 at a rising edge: synchronizer flops = 1 (released), all FSMs = RELEASED, all counters = 0, all outputs = 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL abort without any pulse; a key still held after reset release SHALL be re-debounced and produce a fresh press after 2+DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3)
REQ-030 Clean press: i_key[0] 1->0 held, sampled at edge k -> o_key_state[0]=1 and o_key_press[0]=1 for one cycle at k+6; o_any_press=1 in the same cycle.
REQ-031 Bounce: i_key[1] low 3 cycles, high 1 cycle, then low held -> no pulse until 6 cycles after the final low; exactly one o_key_press[1].
REQ-032 Repeat: i_repeat_en=1, key 2 held 20 cycles after the press pulse -> o_key_repeat[2] at press+10, +13, +16, +19; never after the release is accepted.
REQ-033 Release glitch: key 3 in PRESSED, 2-cycle high glitch -> o_key_state[3] stays 1; no release or press pulse.
REQ-034 Simultaneous: keys 0 and 3 pressed on the same edge -> o_key_press=4'b1001 in a single cycle; release -> o_key_release=4'b1001.
REQ-035 Reset mid-hold: key 0 held, i_reset_n=0 for 1 cycle -> all outputs 0 next cycle; fresh o_key_press[0] 6 cycles after reset release.

Source files
------------

// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, per-key press/release
// debounce FSM, one-cycle press/release pulses and a held-key auto-repeat generator.
module key_debouncer #(
    parameter int NUM_KEYS             = 4,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [NUM_KEYS-1:0] i_key,
    input  logic                i_repeat_en,
    output logic [NUM_KEYS-1:0] o_key_state,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_repeat,
    output logic                o_any_press
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_DR > REPEAT_PERIOD_CYCLES) ? MAX_DR : REPEAT_PERIOD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters hold "cycles seen minus one", so the terminal compare is against N-1.
    localparam cnt_t DB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t DLY_LAST = cnt_t'(REPEAT_DELAY_CYCLES - 1);
    localparam cnt_t PER_LAST = cnt_t'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHECK,
        PRESSED,
        RELEASE_CHECK
    } state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    state_e              state_q     [NUM_KEYS];
    state_e              state_d     [NUM_KEYS];
    cnt_t                db_cnt_q    [NUM_KEYS];
    cnt_t                db_cnt_d    [NUM_KEYS];
    cnt_t                rpt_cnt_q   [NUM_KEYS];
    cnt_t                rpt_cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] rpt_phase_q, rpt_phase_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic [NUM_KEYS-1:0] level;

    always_comb begin
        sync1_d     = i_key;
        sync2_d     = sync1_q;
        level       = ~sync2_q;
        rpt_phase_d = rpt_phase_q;
        press_d     = '0;
        release_d   = '0;
        repeat_d    = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_d[i]   = state_q[i];
            db_cnt_d[i]  = db_cnt_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            case (state_q[i])
                RELEASED: begin
                    db_cnt_d[i]    = '0;
                    rpt_cnt_d[i]   = '0;
                    rpt_phase_d[i] = 1'b0;
                    if (level[i]) state_d[i] = PRESS_CHECK;
                end
                PRESS_CHECK: begin
                    rpt_cnt_d[i]   = '0;
                    rpt_phase_d[i] = 1'b0;
                    if (!level[i]) begin
                        state_d[i]  = RELEASED;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_LAST) begin
                        state_d[i]  = PRESSED;
                        db_cnt_d[i] = '0;
                        press_d[i]  = 1'b1;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + cnt_t'(1);
                    end
                end
                PRESSED: begin
                    db_cnt_d[i] = '0;
                    // Leaving for RELEASE_CHECK freezes the schedule and suppresses any due pulse.
                    if (!level[i]) begin
                        state_d[i] = RELEASE_CHECK;
                    end else if (rpt_cnt_q[i] == (rpt_phase_q[i] ? PER_LAST : DLY_LAST)) begin
                        repeat_d[i]    = i_repeat_en;
                        rpt_cnt_d[i]   = '0;
                        rpt_phase_d[i] = 1'b1;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + cnt_t'(1);
                    end
                end
                RELEASE_CHECK: begin
                    if (level[i]) begin
                        state_d[i]  = PRESSED;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_LAST) begin
                        state_d[i]   = RELEASED;
                        db_cnt_d[i]  = '0;
                        release_d[i] = 1'b1;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + cnt_t'(1);
                    end
                end
                default: state_d[i] = RELEASED;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            rpt_phase_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            repeat_q    <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i]   <= RELEASED;
                db_cnt_q[i]  <= '0;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rpt_phase_q <= rpt_phase_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i]   <= state_d[i];
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    always_comb begin
        o_key_state = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            o_key_state[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_CHECK);
        end
    end

    assign o_key_press   = press_q;
    assign o_key_release = release_q;
    assign o_key_repeat  = repeat_q;
    assign o_any_press   = |press_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with short debounce/repeat parameters:
// per-cycle vector table plus sequences for bounce, repeat, glitch and reset.
module tb_key_debouncer;

    localparam int NK  = 4;
    localparam int DC  = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key;
    logic          rep_en;
    logic [NK-1:0] st, pr, rl, rp;
    logic          any;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    key_debouncer #(
        .NUM_KEYS             (NK),
        .DEBOUNCE_CYCLES      (DC),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_key         (key),
        .i_repeat_en   (rep_en),
        .o_key_state   (st),
        .o_key_press   (pr),
        .o_key_release (rl),
        .o_key_repeat  (rp),
        .o_any_press   (any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] key;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic r, input logic [3:0] k,
                                input logic [3:0] s, input logic [3:0] p,
                                input logic [3:0] l, input logic a);
        vec_t v;
        v.rst_n = r; v.key = k; v.st = s; v.pr = p; v.rl = l; v.any = a;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Steps until the selected pulse appears; an expired budget is a failed comparison.
    task automatic wait_evt(input bit is_rel, input int idx, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = is_rel ? rl[idx] : pr[idx];
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic run_repeat(input int en_from);
        int got[$];
        int exp_q[$];
        int rel_at = -1;
        key    = 4'b1011;
        rep_en = 1'b0;
        wait_evt(1'b0, 2, "rpt_press_seen");
        for (int j = 1; j <= 40; j++) begin
            key    = (j < 20) ? 4'b1011 : 4'b1111;
            rep_en = (j >= en_from);
            step();
            if (rp[2]) got.push_back(j);
            if (rl[2]) rel_at = j;
        end
        rep_en = 1'b0;
        for (int t = 10; t <= 19; t += 3) if (t >= en_from) exp_q.push_back(t);
        check("rpt_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check("rpt_offset", got[i], exp_q[i]);
        check("rpt_release_at", rel_at, 26);
    endtask

    initial begin
        int npress;
        int at;
        int bad;

        add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(6, 1, 4'hE, 4'h0, 4'h0, 4'h0, 0);
        add(1, 1, 4'hE, 4'h1, 4'h1, 4'h0, 1);
        add(1, 1, 4'hE, 4'h1, 4'h0, 4'h0, 0);
        add(6, 1, 4'hF, 4'h1, 4'h0, 4'h0, 0);
        add(1, 1, 4'hF, 4'h0, 4'h0, 4'h1, 0);
        add(1, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(6, 1, 4'h6, 4'h0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h6, 4'h9, 4'h9, 4'h0, 1);
        add(1, 1, 4'h6, 4'h9, 4'h0, 4'h0, 0);
        add(6, 1, 4'hF, 4'h9, 4'h0, 4'h0, 0);
        add(1, 1, 4'hF, 4'h0, 4'h0, 4'h9, 0);
        add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);

        rst_n  = 1'b0;
        key    = 4'hF;
        rep_en = 1'b0;

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            key   = vecs[i].key;
            step();
            check("vec_state",   st,  vecs[i].st);
            check("vec_press",   pr,  vecs[i].pr);
            check("vec_release", rl,  vecs[i].rl);
            check("vec_repeat",  rp,  4'h0);
            check("vec_any",     any, vecs[i].any);
        end

        // Bounce on key 1: 3 low, 1 high, then held low.
        npress = 0;
        at     = -1;
        key    = 4'b1101;
        repeat (3) begin step(); if (pr[1]) npress++; end
        key = 4'b1111;
        step(); if (pr[1]) npress++;
        key = 4'b1101;
        for (int j = 0; j < 20; j++) begin
            step();
            if (pr[1]) begin npress++; at = j; end
        end
        check("bounce_npress", npress, 1);
        check("bounce_press_at", at, 6);
        key = 4'hF;
        wait_evt(1'b1, 1, "bounce_release_seen");
        repeat (3) step();

        run_repeat(1);
        repeat (3) step();
        run_repeat(11);
        repeat (3) step();

        // Release glitch on key 3.
        key = 4'b0111;
        wait_evt(1'b0, 3, "glitch_press_seen");
        repeat (3) step();
        bad = 0;
        key = 4'hF;
        repeat (2) begin step(); if (rl[3] || pr[3] || !st[3]) bad++; end
        key = 4'b0111;
        repeat (12) begin step(); if (rl[3] || pr[3] || !st[3]) bad++; end
        check("glitch_disturbances", bad, 0);
        key = 4'hF;
        wait_evt(1'b1, 3, "glitch_release_seen");
        repeat (3) step();

        // Reset mid-hold on key 0, key kept low through reset.
        key = 4'hE;
        wait_evt(1'b0, 0, "rst_press_seen");
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("rst_state",   st,  4'h0);
        check("rst_press",   pr,  4'h0);
        check("rst_release", rl,  4'h0);
        check("rst_repeat",  rp,  4'h0);
        check("rst_any",     any, 1'b0);
        rst_n  = 1'b1;
        npress = 0;
        at     = -1;
        for (int j = 0; j < 10; j++) begin
            step();
            if (pr[0]) begin npress++; at = j; end
        end
        check("rst_npress", npress, 1);
        check("rst_press_at", at, 6);
        key = 4'hF;
        wait_evt(1'b1, 0, "rst_release_seen");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1);
    end

endmodule
